// File: rtl/dcs_requant_if.sv
// Stream bundle for dcs_requant: unthrottled element input, valid/ready byte output, status flags.
interface dcs_requant_if #(
   parameter int unsigned IN_W  = 32,
   parameter int unsigned OUT_W = 8,
   parameter int unsigned SH_W  = 5
);
   logic              in_valid;
   logic [IN_W-1:0]   in_data;
   logic              out_ready;
   logic              out_valid;
   logic [OUT_W-1:0]  out_data;
   logic              out_last;
   logic [SH_W-1:0]   out_shift;
   logic              busy;
   logic              overflow;

   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data, out_last, out_shift, busy, overflow
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data, out_last, out_shift, busy, overflow
   );
endinterface

// File: rtl/dcs_requant.sv
// Block-floating-point requantizer: buffers one vector, picks a shared shift from its max,
// then replays rounded/saturated elements on a valid/ready stream.
module dcs_requant #(
   parameter int unsigned N_ELEM = 8,
   parameter int unsigned IN_W   = 32,
   parameter int unsigned OUT_W  = 8,
   parameter int unsigned SH_W   = 5
) (
   input logic          clk,
   input logic          rst_n,
   dcs_requant_if.slave bus
);
   localparam int unsigned CNT_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
   localparam int unsigned SUM_W = IN_W + 1;

   typedef enum logic [1:0] {COLLECT, SHIFT, EMIT} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  wr_cnt_q, rd_cnt_q;
   logic [IN_W-1:0]   max_q;
   logic [IN_W-1:0]   mem_q [N_ELEM];
   logic [SH_W-1:0]   msb_c, sh_c;
   logic [CNT_W-1:0]  rd_nxt_c;
   logic              in_take_c, hs_c, last_wr_c, last_rd_c;

   // Round-half-up in IN_W+1 bits so an all-ones input cannot wrap, then clamp to OUT_W.
   function automatic logic [OUT_W-1:0] requant(input logic [IN_W-1:0] x,
                                                input logic [SH_W-1:0] sh);
      logic [SUM_W-1:0] bias;
      logic [SUM_W-1:0] sum;
      logic [SUM_W-1:0] shr;
      bias = '0;
      if (sh != '0) bias = SUM_W'(1) << (sh - SH_W'(1));
      sum = {1'b0, x} + bias;
      shr = sum >> sh;
      if (shr > SUM_W'({OUT_W{1'b1}})) requant = '1;
      else                             requant = shr[OUT_W-1:0];
   endfunction

   // Leading-one position of the vector max; zero max yields shift 0.
   always_comb begin
      msb_c = '0;
      for (int i = 0; i < int'(IN_W); i++) begin
         if (max_q[i]) msb_c = SH_W'(i);
      end
      sh_c = (msb_c > SH_W'(OUT_W - 1)) ? msb_c - SH_W'(OUT_W - 1) : '0;
   end

   assign in_take_c = bus.in_valid && (state_q == COLLECT);
   assign hs_c      = (state_q == EMIT) && bus.out_valid && bus.out_ready;
   assign last_wr_c = (wr_cnt_q == CNT_W'(N_ELEM - 1));
   assign last_rd_c = (rd_cnt_q == CNT_W'(N_ELEM - 1));
   assign rd_nxt_c  = rd_cnt_q + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= COLLECT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT: if (in_take_c && last_wr_c) state_d = SHIFT;
         SHIFT:   state_d = EMIT;
         EMIT:    if (hs_c && last_rd_c) state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   // Vector buffer; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (in_take_c) mem_q[wr_cnt_q] <= bus.in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt_q      <= '0;
         rd_cnt_q      <= '0;
         max_q         <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_last  <= 1'b0;
         bus.out_shift <= '0;
         bus.busy      <= 1'b0;
         bus.overflow  <= 1'b0;
      end else begin
         bus.busy <= (state_d != COLLECT);
         if (bus.in_valid && (state_q != COLLECT)) bus.overflow <= 1'b1;

         if (in_take_c) begin
            wr_cnt_q <= last_wr_c ? '0 : wr_cnt_q + CNT_W'(1);
            if (bus.in_data > max_q) max_q <= bus.in_data;
         end

         // Preload element 0 so out_valid rises straight out of SHIFT.
         if (state_q == SHIFT) begin
            bus.out_shift <= sh_c;
            max_q         <= '0;
            rd_cnt_q      <= '0;
            bus.out_valid <= 1'b1;
            bus.out_data  <= requant(mem_q[0], sh_c);
            bus.out_last  <= (N_ELEM == 1);
         end

         if (hs_c) begin
            if (last_rd_c) begin
               rd_cnt_q      <= '0;
               bus.out_valid <= 1'b0;
               bus.out_last  <= 1'b0;
            end else begin
               rd_cnt_q     <= rd_nxt_c;
               bus.out_data <= requant(mem_q[rd_nxt_c], bus.out_shift);
               bus.out_last <= (rd_nxt_c == CNT_W'(N_ELEM - 1));
            end
         end
      end
   end
endmodule

// File: tb/tb_dcs_requant.sv
// Directed vector bench for dcs_requant: table of vectors plus backpressure, drop and reset sequences.
module tb_dcs_requant;
   localparam int unsigned N_ELEM = 8;
   localparam int unsigned IN_W   = 32;
   localparam int unsigned OUT_W  = 8;
   localparam int unsigned SH_W   = 5;
   localparam int          NV     = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dcs_requant_if #(.IN_W(IN_W), .OUT_W(OUT_W), .SH_W(SH_W)) bus ();

   dcs_requant #(.N_ELEM(N_ELEM), .IN_W(IN_W), .OUT_W(OUT_W), .SH_W(SH_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [IN_W-1:0]  din  [N_ELEM];
      logic [SH_W-1:0]  sh;
      logic [OUT_W-1:0] dout [N_ELEM];
      bit               gaps;
      bit               rnd;
   } vec_t;

   vec_t tbl [NV];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Feed one vector; afterwards the DUT is one edge into EMIT with element 0 presented.
   task automatic send_vec(input int v);
      for (int i = 0; i < int'(N_ELEM); i++) begin
         if (tbl[v].gaps) begin
            repeat ($urandom_range(0, 3)) begin
               bus.in_valid = 1'b0;
               tick();
            end
         end
         chk($sformatf("v%0d collect_busy%0d", v, i), 64'(bus.busy), 64'd0);
         bus.in_valid = 1'b1;
         bus.in_data  = tbl[v].din[i];
         tick();
      end
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      chk($sformatf("v%0d shift_valid", v), 64'(bus.out_valid), 64'd0);
      chk($sformatf("v%0d shift_busy", v), 64'(bus.busy), 64'd1);
      tick();
      chk($sformatf("v%0d emit_rise", v), 64'(bus.out_valid), 64'd1);
   endtask

   // Check elements first..stop-1 through handshakes; stop==N_ELEM drains the vector.
   task automatic emit(input int v, input int first, input int stop);
      int idx = first;
      int cyc = 0;
      bit rdy;
      while (idx < stop && cyc < 200) begin
         rdy = tbl[v].rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.out_ready = rdy;
         chk($sformatf("v%0d e%0d valid", v, idx), 64'(bus.out_valid), 64'd1);
         chk($sformatf("v%0d e%0d data", v, idx), 64'(bus.out_data), 64'(tbl[v].dout[idx]));
         chk($sformatf("v%0d e%0d last", v, idx), 64'(bus.out_last),
             64'(idx == int'(N_ELEM) - 1));
         chk($sformatf("v%0d e%0d shift", v, idx), 64'(bus.out_shift), 64'(tbl[v].sh));
         if (rdy) idx++;
         tick();
         cyc++;
      end
      if (idx < stop) chk($sformatf("v%0d emit_timeout", v), 64'(idx), 64'(stop));
      bus.out_ready = 1'b1;
      if (stop == int'(N_ELEM)) begin
         chk($sformatf("v%0d done_valid", v), 64'(bus.out_valid), 64'd0);
         chk($sformatf("v%0d done_busy", v), 64'(bus.busy), 64'd0);
      end
   endtask

   initial begin
      tbl[0] = '{din: '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
                 sh: 5'd0, dout: '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8},
                 gaps: 1'b0, rnd: 1'b0};
      tbl[1] = '{din: '{32'd1000, 32'd6, 32'd0, 32'd255, 32'd512, 32'd3, 32'd999, 32'd100},
                 sh: 5'd2, dout: '{8'd250, 8'd2, 8'd0, 8'd64, 8'd128, 8'd1, 8'd250, 8'd25},
                 gaps: 1'b0, rnd: 1'b0};
      tbl[2] = '{din: '{32'd1023, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7},
                 sh: 5'd2, dout: '{8'd255, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2},
                 gaps: 1'b1, rnd: 1'b1};
      tbl[3] = '{din: '{32'hFFFF_FFFF, 32'h0, 32'h0100_0000, 32'h0080_0000,
                        32'h7FFF_FFFF, 32'h00FF_FFFF, 32'h8000_0000, 32'h0040_0000},
                 sh: 5'd24, dout: '{8'd255, 8'd0, 8'd1, 8'd1, 8'd128, 8'd1, 8'd128, 8'd0},
                 gaps: 1'b0, rnd: 1'b1};
      tbl[4] = '{din: '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                 sh: 5'd0, dout: '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                 gaps: 1'b0, rnd: 1'b0};
      tbl[5] = '{din: '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                 sh: 5'd0, dout: '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                 gaps: 1'b1, rnd: 1'b1};
      tbl[6] = '{din: '{32'd256, 32'd255, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7},
                 sh: 5'd1, dout: '{8'd128, 8'd128, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4},
                 gaps: 1'b1, rnd: 1'b0};
      tbl[7] = '{din: '{32'd200, 32'd255, 32'd0, 32'd17, 32'd99, 32'd1, 32'd128, 32'd254},
                 sh: 5'd0, dout: '{8'd200, 8'd255, 8'd0, 8'd17, 8'd99, 8'd1, 8'd128, 8'd254},
                 gaps: 1'b1, rnd: 1'b1};

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (3) tick();
      chk("rst out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst out_data", 64'(bus.out_data), 64'd0);
      chk("rst out_last", 64'(bus.out_last), 64'd0);
      chk("rst out_shift", 64'(bus.out_shift), 64'd0);
      chk("rst busy", 64'(bus.busy), 64'd0);
      chk("rst overflow", 64'(bus.overflow), 64'd0);
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < NV; v++) begin
         send_vec(v);
         emit(v, 0, int'(N_ELEM));
         chk($sformatf("v%0d shift_hold", v), 64'(bus.out_shift), 64'(tbl[v].sh));
      end
      chk("overflow clean", 64'(bus.overflow), 64'd0);

      // Backpressure on element 3 with a dropped word, then a dropped word on the final handshake.
      send_vec(1);
      emit(1, 0, 3);
      bus.out_ready = 1'b0;
      for (int h = 0; h < 3; h++) begin
         bus.in_valid = (h == 1);
         bus.in_data  = 32'hDEAD_BEEF;
         chk($sformatf("hold%0d data", h), 64'(bus.out_data), 64'(tbl[1].dout[3]));
         chk($sformatf("hold%0d last", h), 64'(bus.out_last), 64'd0);
         chk($sformatf("hold%0d shift", h), 64'(bus.out_shift), 64'(tbl[1].sh));
         chk($sformatf("hold%0d valid", h), 64'(bus.out_valid), 64'd1);
         tick();
      end
      bus.in_valid = 1'b0;
      chk("drop overflow", 64'(bus.overflow), 64'd1);
      emit(1, 3, int'(N_ELEM) - 1);
      chk("final data", 64'(bus.out_data), 64'(tbl[1].dout[N_ELEM-1]));
      chk("final last", 64'(bus.out_last), 64'd1);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'd77;
      tick();
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      chk("final exit valid", 64'(bus.out_valid), 64'd0);
      chk("final exit busy", 64'(bus.busy), 64'd0);
      send_vec(7);
      emit(7, 0, int'(N_ELEM));
      chk("overflow sticky", 64'(bus.overflow), 64'd1);

      // Asynchronous reset while element 4 is presented.
      send_vec(2);
      emit(2, 0, 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset out_valid", 64'(bus.out_valid), 64'd0);
      chk("areset overflow", 64'(bus.overflow), 64'd0);
      chk("areset busy", 64'(bus.busy), 64'd0);
      chk("areset out_shift", 64'(bus.out_shift), 64'd0);
      chk("areset out_last", 64'(bus.out_last), 64'd0);
      tick();
      chk("areset held valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      send_vec(3);
      emit(3, 0, int'(N_ELEM));
      chk("post reset overflow", 64'(bus.overflow), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dcs_requant.md
Name: dcs_requant

Overview:
- Downstream stage of the DCS attention-projection core.
- Consumes the core's serial burst of N_ELEM 32-bit unsigned results (one vector per token group).
- Picks one block-floating-point shift per vector so the vector maximum fits OUT_W bits. Rounds and saturates every element, then replays the vector as OUT_W-bit bytes on a valid/ready stream to the next layer.
- The upstream core has no backpressure, so this block buffers a whole vector and flags words that arrive while it is busy.

Parameters:
- N_ELEM, 8, elements per vector (words per input burst).
- IN_W, 32, input element width (unsigned).
- OUT_W, 8, output element width (unsigned).
- SH_W, 5, width of shift value; equals clog2(IN_W).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data holds a valid element this cycle; no ready returned.
- in_data  input  IN_W  unsigned element, vector order 0..N_ELEM-1.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_valid  output  1  out_data/out_last/out_shift valid.
- out_data  output  OUT_W  requantized element.
- out_last  output  1  high with element N_ELEM-1.
- out_shift  output  SH_W  shift applied to the current vector; constant across the vector.
- busy  output  1  high in SHIFT or EMIT.
- overflow  output  1  sticky: an input word was dropped.

Behaviour:
- Reset (async, any state): state=COLLECT, element counters=0, running max=0, buffer contents don't-care. Outputs: out_valid=0, out_data=0, out_last=0, out_shift=0, busy=0, overflow=0. Reset mid-EMIT aborts the vector with no further output.
- State machine: COLLECT -> SHIFT -> EMIT -> COLLECT.
- COLLECT:
  - Each in_valid cycle writes in_data to buf[wr_cnt], increments wr_cnt and updates max = max(max, in_data).
  - Gaps (in_valid=0) are allowed and only stall collection.
  - When wr_cnt==N_ELEM-1 with in_valid=1, the next state is SHIFT and wr_cnt wraps to 0.
- SHIFT (exactly 1 cycle):
  - m = index of the most significant 1 in max; if max==0 then sh=0; else sh = max(0, m-(OUT_W-1)).
  - sh is registered into out_shift; max is cleared.
  - Next state is EMIT.
- EMIT:
  - out_valid=1 with out_data = sat(round(buf[rd_cnt])).
  - round(x) = (x + (sh>0 ? 1<<(sh-1) : 0)) >> sh, computed in IN_W+1 bits so there is no wrap.
  - sat(): results > 2^OUT_W-1 become 2^OUT_W-1.
  - out_last = (rd_cnt==N_ELEM-1).
  - On out_valid&&out_ready, rd_cnt increments. On the last element the block returns to COLLECT the next cycle with out_valid=0.
  - While out_ready=0, out_data, out_last and out_shift stay stable.
  - out_data is driven from a registered or combinational path off buf[rd_cnt]; in either case it is stable for as long as out_valid is high and unaccepted.
- Latency: the 8th input word is accepted at edge t, SHIFT runs during t..t+1, and out_valid rises after edge t+1. With out_ready=1 the whole vector drains in N_ELEM cycles.
- Drop rule:
  - in_valid=1 in SHIFT or EMIT drops the word (buffer, max and wr_cnt are unchanged) and sets overflow=1.
  - overflow clears only on reset.
  - In the final EMIT cycle (last handshake), incoming in_valid is still dropped. Collection resumes the cycle after.
- busy = (state != COLLECT).
- out_shift holds its value after EMIT until the next SHIFT.

Test Plan:
- Vector 1,2,3,4,5,6,7,8 with out_ready=1 -> out_shift=0; out_data 1..8 on consecutive cycles; out_last only on 8; out_valid rises 2 edges after the 8th input.
- Vector 1000,6,0,255,512,3,999,100 -> max msb=9, out_shift=2; outputs 250,2,0,64,128,1,250,25.
- Vector containing 1023 and 0xFFFFFFFF (separate runs) -> 1023: shift 2, 1025>>2=256 saturates to 255. 0xFFFFFFFF: shift 24, 33-bit round gives 256, saturates to 255; no wrap to 0.
- All-zero vector -> out_shift=0, eight 0 outputs, out_last on the 8th; input bursts split by random gaps give identical results.
- Backpressure: out_ready=0 for 3 cycles while element 3 is presented -> out_data/out_last/out_shift stable, no element skipped or duplicated. Then in_valid=1 during EMIT -> overflow=1 sticky, emitted data unchanged, next vector collected correctly.
- Assert rst_n=0 asynchronously mid-EMIT (element 4) -> out_valid=0 immediately, overflow=0. After release, a fresh 8-word vector produces correct output from element 0.
